// File: rtl/ifid_pipe.sv
// IF/ID pipeline register with stall/flush sequencing for the 5-stage MIPS core.
// Also counts stalls and flushes, and forces a stalled pipe to move on after MAX_STALL cycles.
module ifid_pipe #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int                CNT_W     = 16,
  parameter int                MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc4,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              if_valid,
  input  logic              hazard,
  input  logic              flush,
  output logic [DATA_W-1:0] id_pc4,
  output logic [DATA_W-1:0] id_instr,
  output logic              id_valid,
  output logic              pc_write,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              stall_timeout
);

  localparam int RL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [0:0]      state;
  logic [RL_W-1:0] run_len;
  logic            stall_eff;
  logic            watchdog;

  // A hazard only holds the pipe when decode has a real instruction to protect.
  assign stall_eff   = hazard & id_valid & ~flush & (run_len < RL_MAX);
  assign watchdog    = (state == S_STALL) & hazard & ~flush & (run_len == RL_MAX);
  assign pc_write    = ~stall_eff;
  assign idex_bubble = stall_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc4        <= '0;
      id_instr      <= NOP_INSTR;
      id_valid      <= 1'b0;
      run_len       <= '0;
      state         <= S_RUN;
      stall_count   <= '0;
      flush_count   <= '0;
      stall_timeout <= 1'b0;
    end else if (flush) begin
      id_pc4   <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
      run_len  <= '0;
      state    <= S_RUN;
      if (flush_count != {CNT_W{1'b1}})
        flush_count <= flush_count + CNT_W'(1);
    end else if (stall_eff) begin
      run_len <= run_len + RL_W'(1);
      state   <= S_STALL;
      if (stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end else begin
      id_pc4   <= if_pc4;
      id_instr <= if_valid ? if_instr : NOP_INSTR;
      id_valid <= if_valid;
      run_len  <= '0;
      state    <= S_RUN;
      if (watchdog)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_pipe.sv
// Bench for ifid_pipe: directed literal checks plus random traffic against a behavioural model.
module tb_ifid_pipe;
  localparam int          DW  = 32;
  localparam int          CW  = 8;
  localparam int          MS  = 3;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] if_pc4 = '0, if_instr = '0;
  logic          if_valid = 1'b0, hazard = 1'b0, flush = 1'b0;
  logic [DW-1:0] id_pc4, id_instr;
  logic          id_valid, pc_write, idex_bubble, stall_timeout;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  ifid_pipe #(.DATA_W(DW), .NOP_INSTR(NOP), .CNT_W(CW), .MAX_STALL(MS)) dut (
    .clk(clk), .rst(rst), .if_pc4(if_pc4), .if_instr(if_instr), .if_valid(if_valid),
    .hazard(hazard), .flush(flush), .id_pc4(id_pc4), .id_instr(id_instr),
    .id_valid(id_valid), .pc_write(pc_write), .idex_bubble(idex_bubble),
    .stall_count(stall_count), .flush_count(flush_count), .stall_timeout(stall_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus the length of the current stall run.
  logic [31:0] m_pc4 = '0, m_instr = NOP;
  bit          m_valid = 0, m_to = 0, m_known = 0;
  int          m_run = 0, m_sc = 0, m_fc = 0;

  function automatic bit m_stall();
    return hazard && m_valid && !flush && (m_run < MS);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc4 <= '0; m_instr <= NOP; m_valid <= 0; m_run <= 0;
      m_sc <= 0; m_fc <= 0; m_to <= 0; m_known <= 1;
    end else if (flush) begin
      m_pc4 <= '0; m_instr <= NOP; m_valid <= 0; m_run <= 0;
      m_fc <= (m_fc >= SAT) ? SAT : m_fc + 1;
    end else if (m_stall()) begin
      m_run <= m_run + 1;
      m_sc  <= (m_sc >= SAT) ? SAT : m_sc + 1;
    end else begin
      if (hazard && m_run == MS) m_to <= 1;
      m_pc4   <= if_pc4;
      m_instr <= if_valid ? if_instr : NOP;
      m_valid <= if_valid;
      m_run   <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("id_pc4", id_pc4, m_pc4);
      chk("id_instr", id_instr, m_instr);
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("pc_write", 32'(pc_write), 32'(!m_stall()));
      chk("idex_bubble", 32'(idex_bubble), 32'(m_stall()));
      chk("stall_count", 32'(stall_count), 32'(m_sc));
      chk("flush_count", 32'(flush_count), 32'(m_fc));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset, then a first load
    rst = 1; tick(); tick();
    chk("rst id_valid", 32'(id_valid), 0);
    chk("rst id_instr", id_instr, NOP);
    chk("rst stall_count", 32'(stall_count), 0);
    rst = 0;
    if_pc4 = 32'h4; if_instr = 32'h8C08_0000; if_valid = 1;
    tick();
    chk("t1 id_instr", id_instr, 32'h8C08_0000);
    chk("t1 id_pc4", id_pc4, 32'h4);
    chk("t1 id_valid", 32'(id_valid), 1);
    chk("t1 pc_write", 32'(pc_write), 1);

    // T2: single-cycle stall
    hazard = 1; if_pc4 = 32'h8; if_instr = 32'h2009_0001;
    #1;
    chk("t2 pc_write", 32'(pc_write), 0);
    chk("t2 idex_bubble", 32'(idex_bubble), 1);
    tick();
    chk("t2 hold id_instr", id_instr, 32'h8C08_0000);
    chk("t2 stall_count", 32'(stall_count), 1);
    hazard = 0;
    tick();
    chk("t2 load id_instr", id_instr, 32'h2009_0001);
    chk("t2 load id_pc4", id_pc4, 32'h8);

    // T3: hazard held 5 cycles -> 3 stalls, forced load, then stalling again
    hazard = 1; if_pc4 = 32'hC; if_instr = 32'h1111_1111;
    #1;
    chk("t3 pc_write c1", 32'(pc_write), 0);
    tick(); tick(); tick();
    chk("t3 stall_count after 3", 32'(stall_count), 4);
    chk("t3 pc_write forced", 32'(pc_write), 1);
    chk("t3 no timeout yet", 32'(stall_timeout), 0);
    tick();
    chk("t3 stall_timeout", 32'(stall_timeout), 1);
    chk("t3 id_instr", id_instr, 32'h1111_1111);
    chk("t3 stall_count after 4", 32'(stall_count), 4);
    chk("t3 restall pc_write", 32'(pc_write), 0);
    tick();
    hazard = 0;
    chk("t3 stall_count after 5", 32'(stall_count), 5);
    tick();
    chk("t3 timeout sticky", 32'(stall_timeout), 1);

    // T4: flush beats hazard
    flush = 1; hazard = 1;
    #1;
    chk("t4 pc_write", 32'(pc_write), 1);
    chk("t4 idex_bubble", 32'(idex_bubble), 0);
    tick();
    chk("t4 id_instr", id_instr, 32'h0);
    chk("t4 id_valid", 32'(id_valid), 0);
    chk("t4 flush_count", 32'(flush_count), 1);
    chk("t4 stall_count", 32'(stall_count), 5);
    flush = 0;

    // hazard with an empty decode slot is ignored
    #1;
    chk("empty hazard pc_write", 32'(pc_write), 1);
    tick();
    chk("empty hazard stall_count", 32'(stall_count), 5);
    chk("empty hazard id_valid", 32'(id_valid), 1);

    // T6: reset in the middle of a stall
    tick();
    rst = 1;
    tick();
    chk("t6 id_valid", 32'(id_valid), 0);
    chk("t6 stall_count", 32'(stall_count), 0);
    chk("t6 flush_count", 32'(flush_count), 0);
    chk("t6 stall_timeout", 32'(stall_timeout), 0);
    chk("t6 pc_write", 32'(pc_write), 1);
    rst = 0; hazard = 0;

    // T5: counter saturation
    tick();
    hazard = 1;
    repeat (400) tick();
    chk("t5 stall_count sat", 32'(stall_count), SAT);
    repeat (8) tick();
    chk("t5 stall_count held", 32'(stall_count), SAT);
    hazard = 0; flush = 1;
    repeat (300) tick();
    chk("t5 flush_count sat", 32'(flush_count), SAT);
    flush = 0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      hazard   = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 9) == 0);
      if_valid = ($urandom_range(0, 9) < 8);
      if_pc4   = $urandom;
      if_instr = $urandom;
      tick();
    end
    rst = 0; hazard = 0; flush = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
